// File: rtl/uart_word_receiver_if.sv
// Word-level output bundle of the UART word receiver.
// master drives the assembled word, slave is the consumer.
interface uart_word_receiver_if;
  logic [16:0] data_out;
  logic        valid_out;
  logic        error_out;

  modport master (
    output data_out,
    output valid_out,
    output error_out
  );

  modport slave (
    input data_out,
    input valid_out,
    input error_out
  );
endinterface

// File: rtl/uart_word_receiver.sv
// 8N1 byte deserializer plus tagged three-byte assembler
// producing 17-bit words with resync and error pulses.
module uart_word_receiver #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rx_wire_in,
  uart_word_receiver_if.master out_if
);
  localparam int BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_PERIOD / 2;
  localparam int CW         = $clog2(BIT_PERIOD + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_B1, WAIT_B2, WAIT_B3} asm_state_t;
  typedef enum logic [1:0] {TAG_T1, TAG_T2, TAG_T3, TAG_BAD} tag_t;

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  rx_state_t     rx_st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_done;
  logic          frame_err;
  logic          stop_bad;
  tag_t          tag;
  asm_state_t    asm_st;
  logic [5:0]    lo;
  logic [5:0]    mid;
  logic [16:0]   data_q;
  logic          valid_q;
  logic          error_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_wire_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_st     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      stop_bad  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      unique case (rx_st)
        IDLE: begin
          bit_idx <= '0;
          if (rx_prev && !rx_s2) begin
            rx_st <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            rx_st <= rx_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_st <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // After a bad stop bit, hold here until the line idles high
          if (stop_bad) begin
            if (rx_s2) begin
              stop_bad <= 1'b0;
              rx_st    <= IDLE;
            end
          end else if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s2) begin
              byte_done <= 1'b1;
              rx_st     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              stop_bad  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rx_st <= IDLE;
      endcase
    end
  end

  always_comb begin
    tag = TAG_BAD;
    unique case (1'b1)
      shreg[7:6] == 2'b00:  tag = TAG_T1;
      shreg[7:6] == 2'b01:  tag = TAG_T2;
      shreg[7:5] == 3'b100: tag = TAG_T3;
      default:              tag = TAG_BAD;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      asm_st  <= WAIT_B1;
      lo      <= '0;
      mid     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (frame_err) begin
        error_q <= 1'b1;
        asm_st  <= WAIT_B1;
      end else if (byte_done) begin
        unique case (tag)
          TAG_T1: begin
            lo      <= shreg[5:0];
            error_q <= (asm_st != WAIT_B1);
            asm_st  <= WAIT_B2;
          end
          TAG_T2: begin
            if (asm_st == WAIT_B2) begin
              mid    <= shreg[5:0];
              asm_st <= WAIT_B3;
            end else begin
              error_q <= 1'b1;
              asm_st  <= WAIT_B1;
            end
          end
          TAG_T3: begin
            if (asm_st == WAIT_B3) begin
              data_q  <= {shreg[4:0], mid, lo};
              valid_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
            asm_st <= WAIT_B1;
          end
          default: begin
            error_q <= 1'b1;
            asm_st  <= WAIT_B1;
          end
        endcase
      end
    end
  end

  assign out_if.data_out  = data_q;
  assign out_if.valid_out = valid_q;
  assign out_if.error_out = error_q;
endmodule

// File: tb/tb_uart_word_receiver.sv
// Self-checking bench for uart_word_receiver: directed and
// randomized byte streams against a word-level reference model.
module tb_uart_word_receiver;
  localparam int BIT = 10;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b1;
  logic rx_wire_in = 1'b1;

  uart_word_receiver_if u_if ();

  uart_word_receiver #(
    .INPUT_CLOCK_FREQ(1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .rx_wire_in(rx_wire_in),
    .out_if(u_if.master)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int both_cnt = 0;
  int hold_err = 0;
  int start_cyc = 0;

  // event = {kind, data}; kind 1 = word, kind 2 = error
  logic [18:0] got[$];
  int          got_cyc[$];
  logic [18:0] exp[$];

  int          m_state = 0;
  logic [5:0]  m_lo = '0;
  logic [5:0]  m_mid = '0;
  logic [16:0] m_data = '0;

  logic [16:0] prev_data = '0;
  logic        prev_rst = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (u_if.valid_out) begin
      got.push_back({2'b01, u_if.data_out});
      got_cyc.push_back(cyc);
    end
    if (u_if.error_out) begin
      got.push_back({2'b10, 17'h0});
      got_cyc.push_back(cyc);
    end
    if (u_if.valid_out && u_if.error_out) both_cnt++;
    if (rst_n_in && prev_rst && !u_if.valid_out &&
        u_if.data_out !== prev_data) hold_err++;
    prev_data = u_if.data_out;
    prev_rst = rst_n_in;
  end

  // Word-level model: progress counts how many leading bytes of a word
  // have been seen in order.
  function automatic void model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp.push_back({2'b10, 17'h0});
      m_state = 0;
    end else if (b[7:6] == 2'b00) begin
      if (m_state != 0) exp.push_back({2'b10, 17'h0});
      m_lo = b[5:0];
      m_state = 1;
    end else if (b[7:6] == 2'b01 && m_state == 1) begin
      m_mid = b[5:0];
      m_state = 2;
    end else if (b[7:5] == 3'b100 && m_state == 2) begin
      m_data = {b[4:0], m_mid, m_lo};
      exp.push_back({2'b01, m_data});
      m_state = 0;
    end else begin
      exp.push_back({2'b10, 17'h0});
      m_state = 0;
    end
  endfunction

  task automatic idle(input int n);
    rx_wire_in = 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic tx(input logic [7:0] b, input bit bad);
    start_cyc = cyc;
    rx_wire_in = 1'b0;
    repeat (BIT) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx_wire_in = b[i];
      repeat (BIT) @(negedge clk_in);
    end
    rx_wire_in = !bad;
    repeat (BIT) @(negedge clk_in);
    rx_wire_in = 1'b1;
    model_byte(b, bad);
  endtask

  task automatic clear;
    got.delete();
    got_cyc.delete();
    exp.delete();
  endtask

  task automatic apply_reset(input int n);
    rst_n_in = 1'b0;
    repeat (n) @(negedge clk_in);
    rst_n_in = 1'b1;
    m_state = 0;
    m_data = '0;
  endtask

  task automatic test_reset;
    rx_wire_in = 1'b1;
    @(negedge clk_in);
    apply_reset(3);
    n_checks++;
    if (u_if.data_out !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 0", u_if.data_out);
    end
    n_checks++;
    if (u_if.valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b exp 0", u_if.valid_out);
    end
    n_checks++;
    if (u_if.error_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_error got %b exp 0", u_if.error_out);
    end
    idle(5);
  endtask

  task automatic test_single_word;
    clear();
    tx(8'h0D, 0);
    tx(8'h6F, 0);
    tx(8'h9A, 0);
    idle(20);
    n_checks++;
    if (got.size() !== 1 || got[0] !== {2'b01, 17'h1ABCD}) begin
      n_fail++;
      $display("FAIL single_word got n=%0d ev=%h exp 1 ev=%h",
               got.size(), got.size() ? got[0] : 19'h0,
               {2'b01, 17'h1ABCD});
    end
    n_checks++;
    if (got_cyc.size() < 1 || got_cyc[0] !== start_cyc + 99) begin
      n_fail++;
      $display("FAIL single_latency got %0d exp %0d",
               got_cyc.size() ? got_cyc[0] : -1, start_cyc + 99);
    end
  endtask

  task automatic test_back_to_back;
    clear();
    tx(8'h00, 0); tx(8'h40, 0); tx(8'h80, 0);
    tx(8'h3F, 0); tx(8'h7F, 0); tx(8'h9F, 0);
    idle(20);
    n_checks++;
    if (got.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_count got %0d exp 2", got.size());
    end
    n_checks++;
    if (got.size() > 0 && got[0] !== {2'b01, 17'h00000}) begin
      n_fail++;
      $display("FAIL b2b_first got %h exp %h", got[0], {2'b01, 17'h0});
    end
    n_checks++;
    if (got.size() > 1 && got[1] !== {2'b01, 17'h1FFFF}) begin
      n_fail++;
      $display("FAIL b2b_second got %h exp %h", got[1], {2'b01, 17'h1FFFF});
    end
  endtask

  task automatic test_resync;
    clear();
    tx(8'h0D, 0); tx(8'h0D, 0); tx(8'h6F, 0); tx(8'h9A, 0);
    idle(20);
    n_checks++;
    if (got.size() !== 2) begin
      n_fail++;
      $display("FAIL resync_count got %0d exp 2", got.size());
    end
    n_checks++;
    if (got.size() > 1 && (got[0] !== {2'b10, 17'h0} ||
        got[1] !== {2'b01, 17'h1ABCD})) begin
      n_fail++;
      $display("FAIL resync_events got %h %h exp %h %h", got[0], got[1],
               {2'b10, 17'h0}, {2'b01, 17'h1ABCD});
    end
  endtask

  task automatic test_bad_tag;
    clear();
    tx(8'hC5, 0);
    idle(20);
    n_checks++;
    if (got.size() !== 1 || got[0] !== {2'b10, 17'h0}) begin
      n_fail++;
      $display("FAIL bad_tag got n=%0d exp 1 error", got.size());
    end
    clear();
    tx(8'h6F, 0);
    idle(20);
    n_checks++;
    if (got.size() !== 1 || got[0] !== {2'b10, 17'h0}) begin
      n_fail++;
      $display("FAIL lone_t2 got n=%0d exp 1 error", got.size());
    end
    clear();
    tx(8'h0D, 0); tx(8'h6F, 0); tx(8'h9A, 0);
    idle(20);
    n_checks++;
    if (got.size() !== 1 || got[0] !== {2'b01, 17'h1ABCD}) begin
      n_fail++;
      $display("FAIL bad_tag_recover got n=%0d exp 1 word 1abcd", got.size());
    end
  endtask

  task automatic test_framing_glitch;
    clear();
    tx(8'h0D, 1);
    idle(20);
    n_checks++;
    if (got.size() !== 1 || got[0] !== {2'b10, 17'h0}) begin
      n_fail++;
      $display("FAIL framing got n=%0d exp 1 error", got.size());
    end
    clear();
    rx_wire_in = 1'b0;
    repeat (3) @(negedge clk_in);
    idle(150);
    n_checks++;
    if (got.size() !== 0) begin
      n_fail++;
      $display("FAIL glitch got %0d events exp 0", got.size());
    end
    clear();
    tx(8'h0D, 0); tx(8'h6F, 0); tx(8'h9A, 0);
    idle(20);
    n_checks++;
    if (got.size() !== 1 || got[0] !== {2'b01, 17'h1ABCD}) begin
      n_fail++;
      $display("FAIL glitch_recover got n=%0d exp 1 word", got.size());
    end
  endtask

  task automatic test_reset_mid_word;
    clear();
    tx(8'h0D, 0); tx(8'h6F, 0);
    apply_reset(2);
    idle(10);
    n_checks++;
    if (u_if.data_out !== 17'h0 || got.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_mid got data=%h n=%0d exp data=0 n=0",
               u_if.data_out, got.size());
    end
    tx(8'h9A, 0);
    idle(20);
    n_checks++;
    if (got.size() !== 1 || got[0] !== {2'b10, 17'h0}) begin
      n_fail++;
      $display("FAIL reset_then_t3 got n=%0d exp 1 error", got.size());
    end
  endtask

  task automatic test_random;
    logic [16:0] w;
    clear();
    for (int i = 0; i < 30; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 65) begin
        w = 17'($urandom_range(0, 17'h1FFFF));
        tx({2'b00, w[5:0]}, 0);
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 25)));
        tx({2'b01, w[11:6]}, 0);
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 25)));
        tx({3'b100, w[16:12]}, 0);
      end else if (r < 88) begin
        tx(8'($urandom_range(0, 255)), 0);
      end else begin
        tx(8'($urandom_range(0, 255)), 1);
        idle(20);
      end
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 25)));
    end
    idle(30);
    n_checks++;
    if (got.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL random_count got %0d exp %0d", got.size(), exp.size());
    end
    foreach (exp[i]) begin
      if (i < got.size()) begin
        n_checks++;
        if (got[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL random_event[%0d] got %h exp %h", i, got[i], exp[i]);
        end
      end
    end
    n_checks++;
    if (u_if.data_out !== m_data) begin
      n_fail++;
      $display("FAIL random_hold got %h exp %h", u_if.data_out, m_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_resync();
    test_bad_tag();
    test_framing_glitch();
    test_reset_mid_word();
    test_random();
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL valid_error_overlap got %0d exp 0", both_cnt);
    end
    n_checks++;
    if (hold_err !== 0) begin
      n_fail++;
      $display("FAIL data_hold got %0d changes exp 0", hold_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
